// File: rtl/window_addr_gen_pkg.sv
// Shared accelerator parameters for the window address generator.
// Holds default geometry, the FSM state encoding and a width helper.
package window_addr_gen_pkg;

    localparam int IMG_W_DEF = 8;
    localparam int IMG_H_DEF = 8;
    localparam int K_DEF     = 3;
    localparam int AW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wag_state_e;

    // A counter that only ever holds 0 still needs one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/window_addr_gen_wrap_counter.sv
// Up-counter that runs 0..MAX and wraps back to 0 on an enabled step.
// Exposes its next value so the parent can register derived outputs.
module wrap_counter
    import window_addr_gen_pkg::*;
#(
    parameter int MAX = 2,
    parameter int CW  = cnt_width(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count_nxt,
    output logic          wrap,
    output logic          wrap_nxt
);

    logic [CW-1:0] count;

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (en) begin
            count_nxt = wrap ? '0 : count + 1'b1;
        end
    end

    assign wrap     = (count == CW'(MAX));
    assign wrap_nxt = (count_nxt == CW'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/window_addr_gen.sv
// Sliding-window tap address generator: walks out_row, out_col, ky, kx
// and issues one input-pixel address per accepted handshake.
//
//   state | meaning
//   IDLE  | waiting for start; counters parked at 0
//   RUN   | addr_valid high, counters step on each transfer
//   DONE  | one-cycle done pulse, then back to IDLE
module window_addr_gen
    import window_addr_gen_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic [AW-1:0] addr,
    output logic          tap_last,
    output logic          pix_last,
    output logic          done
);

    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam int KW = cnt_width(K - 1);
    localparam int XW = cnt_width(OW - 1);
    localparam int YW = cnt_width(OH - 1);

    wag_state_e state, state_nxt;

    logic          start_acc, xfer, scan_end;
    logic [KW-1:0] kx_nxt, ky_nxt;
    logic [XW-1:0] ox_nxt;
    logic [YW-1:0] oy_nxt;
    logic          kx_wrap, ky_wrap, ox_wrap, oy_wrap;
    logic          kx_wrap_nxt, ky_wrap_nxt, ox_wrap_nxt, oy_wrap_nxt;
    logic [AW-1:0] addr_nxt;

    assign start_acc = (state == IDLE) && start;
    assign xfer      = (state == RUN) && addr_ready;
    assign scan_end  = xfer && kx_wrap && ky_wrap && ox_wrap && oy_wrap;

    wrap_counter #(.MAX(K - 1)) u_kx (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(xfer),
        .count_nxt(kx_nxt), .wrap(kx_wrap), .wrap_nxt(kx_wrap_nxt)
    );

    wrap_counter #(.MAX(K - 1)) u_ky (
        .clk(clk), .rst_n(rst_n), .clr(start_acc), .en(xfer && kx_wrap),
        .count_nxt(ky_nxt), .wrap(ky_wrap), .wrap_nxt(ky_wrap_nxt)
    );

    wrap_counter #(.MAX(OW - 1)) u_ox (
        .clk(clk), .rst_n(rst_n), .clr(start_acc),
        .en(xfer && kx_wrap && ky_wrap),
        .count_nxt(ox_nxt), .wrap(ox_wrap), .wrap_nxt(ox_wrap_nxt)
    );

    wrap_counter #(.MAX(OH - 1)) u_oy (
        .clk(clk), .rst_n(rst_n), .clr(start_acc),
        .en(xfer && kx_wrap && ky_wrap && ox_wrap),
        .count_nxt(oy_nxt), .wrap(oy_wrap), .wrap_nxt(oy_wrap_nxt)
    );

    // Derived from the counters' next values so addr lands in the same edge.
    assign addr_nxt = AW'((32'(oy_nxt) + 32'(ky_nxt)) * 32'(IMG_W)
                          + 32'(ox_nxt) + 32'(kx_nxt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (scan_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == RUN);
        addr_valid = (state == RUN);
        done       = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            tap_last <= 1'b0;
            pix_last <= 1'b0;
        end else if (start_acc || xfer) begin
            addr     <= addr_nxt;
            tap_last <= kx_wrap_nxt && ky_wrap_nxt;
            pix_last <= kx_wrap_nxt && ky_wrap_nxt && ox_wrap_nxt && oy_wrap_nxt;
        end
    end

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen at default geometry: full scans,
// backpressure, ignored starts, mid-scan reset and back-to-back scans.
module tb_window_addr_gen;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int K     = 3;
    localparam int AW    = 8;
    localparam int OW    = IMG_W - K + 1;
    localparam int NTAP  = (IMG_H - K + 1) * OW * K * K;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          addr_ready = 1'b0;
    logic          busy, addr_valid, tap_last, pix_last, done;
    logic [AW-1:0] addr;

    int n_checks = 0;
    int n_errors = 0;

    window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .tap_last(tap_last), .pix_last(pix_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int n);
        int kx, ky, ox, oy;
        kx = n % K;
        ky = (n / K) % K;
        ox = (n / (K * K)) % OW;
        oy = n / (K * K * OW);
        return (oy + ky) * IMG_W + ox + kx;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(addr_valid), 0);
        chk({tag, "_addr"}, int'(addr), 0);
        chk({tag, "_tap_last"}, int'(tap_last), 0);
        chk({tag, "_pix_last"}, int'(pix_last), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Called on a negedge; start is raised at once so the next posedge takes it.
    task automatic run_scan(input bit bp, input int start_poke, input int rst_at,
                            output int ntx, output int ndone);
        logic [AW-1:0] h_addr;
        logic          h_tl, h_pl;
        bit            stalled, fin;
        int            cyc;
        ntx = 0; ndone = 0; stalled = 0; fin = 0; cyc = 0;
        h_addr = '0; h_tl = 0; h_pl = 0;
        start = 1'b1;
        @(negedge clk);
        while (!fin && cyc < 3000) begin
            start = 1'b0;
            if (stalled && addr_valid) begin
                chk("stall_addr", int'(addr), int'(h_addr));
                chk("stall_tap_last", int'(tap_last), int'(h_tl));
                chk("stall_pix_last", int'(pix_last), int'(h_pl));
            end
            stalled = 0;
            if (done) begin
                ndone++;
                chk("done_busy", int'(busy), 0);
                chk("done_valid", int'(addr_valid), 0);
                chk("done_after_ntx", ntx, NTAP);
                if (!bp) chk("scan_cycles", cyc, NTAP);
                if (start_poke >= 0) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("post_done_busy", int'(busy), 0);
                chk("post_done_done", int'(done), 0);
                fin = 1;
            end else if (!addr_valid) begin
                chk("valid_in_scan", int'(addr_valid), 1);
            end else if (rst_at >= 0 && ntx == rst_at) begin
                #2 rst_n = 1'b0;
                #1 chk_all_zero("async_rst");
                #1 rst_n = 1'b1;
                fin = 1;
            end else begin
                chk("busy_in_scan", int'(busy), 1);
                addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ntx == start_poke) start = 1'b1;
                if (addr_ready) begin
                    chk("addr", int'(addr), exp_addr(ntx));
                    chk("tap_last", int'(tap_last), int'((ntx % (K * K)) == K * K - 1));
                    chk("pix_last", int'(pix_last), int'(ntx == NTAP - 1));
                    ntx++;
                end else begin
                    stalled = 1;
                    h_addr = addr; h_tl = tap_last; h_pl = pix_last;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("scan_timeout", 0, 1);
    endtask

    initial begin
        int ntx, ndone;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge clk);
        chk_all_zero("reset_held");
        rst_n = 1'b1;

        // First start lands on the first rising edge after reset release.
        run_scan(0, -1, -1, ntx, ndone);
        chk("scanA_ntx", ntx, NTAP);
        chk("scanA_done", ndone, 1);

        run_scan(0, -1, -1, ntx, ndone);
        chk("scanB_ntx", ntx, NTAP);
        chk("scanB_done", ndone, 1);

        run_scan(1, -1, -1, ntx, ndone);
        chk("scanC_ntx", ntx, NTAP);
        chk("scanC_done", ndone, 1);

        run_scan(0, 50, -1, ntx, ndone);
        chk("scanD_ntx", ntx, NTAP);
        chk("scanD_done", ndone, 1);
        @(negedge clk);
        chk("scanD_idle_busy", int'(busy), 0);

        run_scan(0, -1, 100, ntx, ndone);
        chk("scanE_ntx", ntx, 100);
        chk("scanE_done", ndone, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_rst_done", int'(done), 0);
            chk("after_rst_busy", int'(busy), 0);
        end

        run_scan(0, -1, -1, ntx, ndone);
        chk("scanF_ntx", ntx, NTAP);
        chk("scanF_done", ndone, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
